// File: rtl/tt_um_trinitytile_cntchk.sv
// Counter-sequence checker: samples an external counter on strobe edges, locks after three
// consecutive +1 steps, and counts errors. Optional LOCK-idle timeout: TRINITYTILE_CNTCHK_TIMEOUT_EN.
module tt_um_trinitytile_cntchk (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_strb_sync;
  logic       r_strb_prev;
  logic [1:0] r_clr_sync;
  logic       r_clr_prev;
  logic [7:0] r_sample_q;
  logic       r_sample_pulse;
  logic [7:0] r_expected;
  logic [1:0] r_match_cnt;
  logic [1:0] w_match_cnt_nxt;
  logic [7:0] r_err_cnt;
  logic       r_err_sticky;
  logic       r_locked;

  logic w_strb_rise;
  logic w_clr_rise;
  logic w_sample_evt;
  logic w_clr_evt;
  logic w_match;
  logic w_err_inc;
  logic w_sticky_set;
  logic w_timeout_hit;
  logic w_timeout_flag;
  logic w_unused;

  assign w_unused = &{1'b0, uio_in[7:3]};

  assign w_strb_rise  = r_strb_sync[1] & ~r_strb_prev;
  assign w_clr_rise   = r_clr_sync[1] & ~r_clr_prev;
  assign w_clr_evt    = ena & w_clr_rise;
  // A simultaneous clear swallows the sample entirely.
  assign w_sample_evt = ena & w_strb_rise & ~w_clr_rise;
  assign w_match      = (ui_in == r_expected);

`ifdef TRINITYTILE_CNTCHK_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        r_timeout;

  assign w_timeout_hit  = ena & ~w_sample_evt & ~w_clr_evt &
                          (r_state == ST_LOCK) & (r_idle_cnt == 16'hFFFE);
  assign w_timeout_flag = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (ena) begin
      if (w_sample_evt || w_clr_evt || (r_state != ST_LOCK))
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 16'd1;

      if (w_clr_evt)
        r_timeout <= 1'b0;
      else if (w_timeout_hit)
        r_timeout <= 1'b1;
    end
  end
`else
  assign w_timeout_hit  = 1'b0;
  assign w_timeout_flag = 1'b0;
`endif

  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    w_err_inc       = 1'b0;
    w_sticky_set    = 1'b0;
    if (w_clr_evt) begin
      w_state_nxt     = ST_IDLE;
      w_match_cnt_nxt = 2'd0;
    end else if (w_sample_evt) begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt     = ST_ACQ;
          w_match_cnt_nxt = 2'd0;
        end
        ST_ACQ: begin
          if (!w_match) begin
            w_match_cnt_nxt = 2'd0;
          end else if (r_match_cnt == 2'd2) begin
            w_state_nxt     = ST_LOCK;
            w_match_cnt_nxt = 2'd3;
          end else begin
            w_match_cnt_nxt = r_match_cnt + 2'd1;
          end
        end
        ST_LOCK: begin
          if (!w_match) begin
            w_state_nxt  = ST_ERR;
            w_err_inc    = 1'b1;
            w_sticky_set = 1'b1;
          end
        end
        ST_ERR: begin
          if (w_match) begin
            w_state_nxt     = ST_ACQ;
            w_match_cnt_nxt = 2'd1;
          end else begin
            w_err_inc = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_timeout_hit) begin
      w_state_nxt  = ST_ERR;
      w_err_inc    = 1'b1;
      w_sticky_set = 1'b1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_strb_sync    <= '0;
      r_strb_prev    <= 1'b0;
      r_clr_sync     <= '0;
      r_clr_prev     <= 1'b0;
      r_sample_q     <= '0;
      r_sample_pulse <= 1'b0;
      r_expected     <= '0;
      r_match_cnt    <= '0;
      r_err_cnt      <= '0;
      r_err_sticky   <= 1'b0;
      r_locked       <= 1'b0;
    end else if (ena) begin
      r_strb_sync    <= {r_strb_sync[0], uio_in[0]};
      r_strb_prev    <= r_strb_sync[1];
      r_clr_sync     <= {r_clr_sync[0], uio_in[1]};
      r_clr_prev     <= r_clr_sync[1];
      r_sample_pulse <= w_sample_evt;
      if (w_sample_evt) begin
        r_sample_q <= ui_in;
        r_expected <= ui_in + 8'd1;
      end
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_locked    <= (w_state_nxt == ST_LOCK);
      if (w_clr_evt) begin
        r_err_cnt    <= '0;
        r_err_sticky <= 1'b0;
      end else begin
        if (w_err_inc && (r_err_cnt != 8'hFF))
          r_err_cnt <= r_err_cnt + 8'd1;
        if (w_sticky_set)
          r_err_sticky <= 1'b1;
      end
    end
  end

  assign uo_out  = uio_in[2] ? r_err_cnt : r_sample_q;
  assign uio_out = {w_timeout_flag, r_sample_pulse, r_err_sticky, r_locked, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_trinitytile_cntchk.sv
// Randomised scoreboard bench for tt_um_trinitytile_cntchk: a rule-level model queues the
// expected result of every sample; a monitor checks it when sample_pulse appears.
`timescale 1ns/1ps
module tb_tt_um_trinitytile_cntchk;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       strb  = 1'b0;
  logic       clr   = 1'b0;
  logic       sel   = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign uio_in = {5'b00000, sel, clr, strb};

  tt_um_trinitytile_cntchk dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       locked;
    logic       sticky;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: tracks the counting history, not the design's state machine.
  bit         m_started;
  bit         m_locked;
  bit         m_in_err;
  int         m_streak;
  int         m_errs;
  bit         m_sticky;
  bit         m_timeout;
  logic [7:0] m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_forget();
    m_started = 0;
    m_locked  = 0;
    m_in_err  = 0;
    m_streak  = 0;
    m_errs    = 0;
    m_sticky  = 0;
    m_timeout = 0;
  endfunction

  function automatic void model_error();
    if (m_errs < 255) m_errs++;
  endfunction

  function automatic void model_sample(input logic [7:0] d);
    logic [7:0] succ;
    bit         hit;
    succ = m_prev + 8'd1;
    hit  = (d == succ);
    if (!m_started) begin
      m_started = 1;
      m_streak  = 0;
    end else if (m_locked) begin
      if (!hit) begin
        m_locked = 0;
        m_in_err = 1;
        m_sticky = 1;
        model_error();
      end
    end else if (m_in_err) begin
      if (hit) begin
        m_in_err = 0;
        m_streak = 1;
      end else begin
        model_error();
      end
    end else if (hit) begin
      m_streak++;
      if (m_streak >= 3) m_locked = 1;
    end else begin
      m_streak = 0;
    end
    m_prev = d;
    sb_q.push_back('{data: d, locked: m_locked, sticky: m_sticky});
  endfunction

  task automatic strobe(input logic [7:0] d);
    ui_in = d;
    @(negedge clk);
    strb = 1'b1;
    model_sample(d);
    repeat (3) @(negedge clk);
    strb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    model_forget();
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    #2;
    sel = 1'b1;
    #1;
    check({tag, "_err_cnt"}, uo_out, m_errs);
    sel = 1'b0;
    #1;
    check({tag, "_locked"}, uio_out[4], m_locked);
    check({tag, "_sticky"}, uio_out[5], m_sticky);
    check({tag, "_timeout"}, uio_out[7], m_timeout);
  endtask

  // Monitor: every sample_pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && uio_out[6]) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: sample_pulse with uo_out=%0h, none expected (t=%0t)",
                 uo_out, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sample_data", uo_out, e.data);
        check("sample_locked", uio_out[4], e.locked);
        check("sample_sticky", uio_out[5], e.sticky);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    model_forget();
    m_prev = 8'h00;

    // Reset values
    #12;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Lock from a clean start
    for (int i = 0; i < 5; i++) strobe(8'h10 + 8'(i));
    check_status("lock_10");

    // Wrap-around is a match
    do_clear();
    for (int i = 0; i < 4; i++) strobe(8'hFB + 8'(i));
    check_status("lock_fe");
    strobe(8'hFF);
    strobe(8'h00);
    strobe(8'h01);
    check_status("wrap");

    // Mismatch in LOCK, then recovery
    do_clear();
    for (int i = 0; i < 4; i++) strobe(8'h1D + 8'(i));
    strobe(8'h55);
    check_status("lock_err");
    strobe(8'h56);
    strobe(8'h57);
    strobe(8'h58);
    check_status("recover");

    // Error counter saturation
    strobe(8'h00);
    for (int i = 0; i < 300; i++) strobe((i % 2 == 0) ? 8'h80 : 8'h00);
    check_status("saturate");

    // Randomised run, biased towards correct successors
    do_clear();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) d = m_prev + 8'd1;
      else d = 8'($urandom);
      strobe(d);
    end
    check_status("random");

    // Clear and strobe edges land in the same cycle
    for (int i = 0; i < 4; i++) strobe(8'h30 + 8'(i));
    ui_in = 8'hA5;
    @(negedge clk);
    strb = 1'b1;
    clr  = 1'b1;
    model_forget();
    repeat (3) @(negedge clk);
    strb = 1'b0;
    clr  = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_wins_sample_q", uo_out, m_prev);
    check_status("clr_wins");

    // Strobes while disabled are ignored
    ena   = 1'b0;
    ui_in = 8'h77;
    @(negedge clk);
    strb = 1'b1;
    repeat (3) @(negedge clk);
    strb = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    check("ena_hold_sample_q", uo_out, m_prev);

    // Reset mid-strobe
    strobe(8'h60);
    strobe(8'h61);
    ui_in = 8'h99;
    @(negedge clk);
    strb = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_uo_out", uo_out, 8'h00);
    check("midrst_uio_out", uio_out, 8'h00);
    check("midrst_uio_oe", uio_oe, 8'hF0);
    sel = 1'b1;
    #1;
    check("midrst_err_cnt", uo_out, 8'h00);
    sel  = 1'b0;
    strb = 1'b0;
    model_forget();
    m_prev = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) strobe(8'h42 + 8'(i));
    check_status("post_rst");

    // Long idle while locked
    repeat (66000) @(negedge clk);
`ifdef TRINITYTILE_CNTCHK_TIMEOUT_EN
    m_locked  = 0;
    m_in_err  = 1;
    m_sticky  = 1;
    m_timeout = 1;
    model_error();
`endif
    check_status("idle");

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
